// File: rtl/biriscv_tcm_mem.sv
// Single-cycle tightly-coupled memory for the dual-issue core: 64-bit fetch port plus a 32-bit tagged load/store port.
// Optional address range check enabled by defining TCM_MEM_ERR_EN.
module biriscv_tcm_mem #(
    parameter int          ADDR_BITS = 17,
    parameter logic [31:0] BASE_ADDR = 32'h80000000
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [63:0] mem_i_inst_o,

    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);

    localparam int IDX_BITS = ADDR_BITS - 3;
    localparam int WORDS    = 1 << IDX_BITS;

    logic [63:0] ram [0:WORDS-1];

    logic [IDX_BITS-1:0] w_i_idx;
    logic [IDX_BITS-1:0] w_d_idx;
    logic                w_d_lane;
    logic                w_d_req;
    logic                w_d_store;
    logic                w_i_err;
    logic                w_d_err;
    logic                w_wr_en;
    logic [7:0]          w_wr_be8;
    logic [63:0]         w_wr_data64;
    logic [63:0]         w_d_word;
    logic [63:0]         w_i_word;
    logic [31:0]         w_d_rdata;

    logic                r_i_valid;
    logic                r_i_err;
    logic [63:0]         r_i_inst;
    logic                r_d_ack;
    logic                r_d_err;
    logic [31:0]         r_d_data;
    logic [10:0]         r_d_tag;

    assign w_i_idx     = mem_i_pc_i[ADDR_BITS-1:3];
    assign w_d_idx     = mem_d_addr_i[ADDR_BITS-1:3];
    assign w_d_lane    = mem_d_addr_i[2];
    assign w_d_store   = |mem_d_wr_i;
    assign w_d_req     = mem_d_rd_i | w_d_store | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;

`ifdef TCM_MEM_ERR_EN
    // Borrow out of the subtraction means below base; any offset bit above ADDR_BITS means past the top.
    function automatic logic out_of_range(input logic [31:0] addr);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        return off[32] | (|off[31:ADDR_BITS]);
    endfunction

    assign w_i_err = out_of_range(mem_i_pc_i);
    assign w_d_err = out_of_range(mem_d_addr_i);
`else
    assign w_i_err = 1'b0;
    assign w_d_err = 1'b0;
`endif

    assign w_wr_en     = rst_i & w_d_store & ~w_d_err;
    assign w_wr_be8    = w_d_lane ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
    assign w_wr_data64 = {mem_d_data_wr_i, mem_d_data_wr_i};
    assign w_d_word    = ram[w_d_idx];
    assign w_i_word    = ram[w_i_idx];

    // Load data: lane of the pre-store word; cache-op-only and erroring requests return zero.
    always_comb begin
        w_d_rdata = 32'h0000_0000;
        if (mem_d_rd_i && !w_d_err) begin
            w_d_rdata = w_d_lane ? w_d_word[63:32] : w_d_word[31:0];
        end else begin
            w_d_rdata = 32'h0000_0000;
        end
    end

    // Byte-lane store into the shared array; reads above see the old contents (read-first).
    always @(posedge clk_i) begin
        for (int b = 0; b < 8; b++) begin
            if (w_wr_en && w_wr_be8[b]) begin
                ram[w_d_idx][b*8 +: 8] <= w_wr_data64[b*8 +: 8];
            end
        end
    end

    // Response registers for both ports, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_i_valid <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_inst  <= 64'h0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_data  <= 32'h0;
            r_d_tag   <= 11'h000;
        end else begin
            r_i_valid <= mem_i_rd_i;
            r_d_ack   <= w_d_req;
            if (mem_i_rd_i) begin
                r_i_err  <= w_i_err;
                r_i_inst <= w_i_err ? 64'h0 : w_i_word;
            end
            if (w_d_req) begin
                r_d_err  <= w_d_err;
                r_d_data <= w_d_rdata;
                r_d_tag  <= mem_d_req_tag_i;
            end
        end
    end

    // Outputs are forced low while reset is held so a response in flight never escapes.
    assign mem_i_accept_o   = 1'b1;
    assign mem_d_accept_o   = 1'b1;
    assign mem_i_valid_o    = r_i_valid & rst_i;
    assign mem_i_error_o    = r_i_err & rst_i;
    assign mem_i_inst_o     = r_i_inst & {64{rst_i}};
    assign mem_d_ack_o      = r_d_ack & rst_i;
    assign mem_d_error_o    = r_d_err & rst_i;
    assign mem_d_data_rd_o  = r_d_data & {32{rst_i}};
    assign mem_d_resp_tag_o = r_d_tag & {11{rst_i}};

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                           mem_i_pc_i[31:ADDR_BITS], mem_i_pc_i[2:0],
                           mem_d_addr_i[31:ADDR_BITS], mem_d_addr_i[1:0], BASE_ADDR};

    // Simulation backdoor: byte access without a clock, used to preload program images.
    task write(input logic [31:0] addr, input logic [7:0] data);
        ram[addr[ADDR_BITS-1:3]][{addr[2:0], 3'b000} +: 8] = data;
    endtask

    function logic [7:0] read(input logic [31:0] addr);
        return ram[addr[ADDR_BITS-1:3]][{addr[2:0], 3'b000} +: 8];
    endfunction

endmodule

// File: tb/tb_biriscv_tcm_mem.sv
// Directed bench for biriscv_tcm_mem: stimulus pushes expected responses, a monitor pops and compares.
module tb_biriscv_tcm_mem;

`ifdef TCM_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [63:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    always #5 clk_i = ~clk_i;

    biriscv_tcm_mem dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
        .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
        .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
        .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
        .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
        .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
        .mem_d_flush_i(mem_d_flush_i), .mem_d_data_rd_o(mem_d_data_rd_o),
        .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
        .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o)
    );

    typedef struct { logic [63:0] inst; logic err; } i_exp_t;
    typedef struct { logic [31:0] data; logic [10:0] tag; logic err; } d_exp_t;

    i_exp_t     q_i[$];
    d_exp_t     q_d[$];
    logic [7:0] q_bd_act[$];
    logic [7:0] q_bd_exp[$];
    int         vectors     = 0;
    int         miscompares = 0;
    bit         done        = 1'b0;

    task automatic clear_req();
        mem_i_rd_i = 1'b0; mem_i_flush_i = 1'b0; mem_i_invalidate_i = 1'b0;
        mem_i_pc_i = 32'h0;
        mem_d_addr_i = 32'h0; mem_d_data_wr_i = 32'h0; mem_d_rd_i = 1'b0;
        mem_d_wr_i = 4'h0; mem_d_cacheable_i = 1'b0; mem_d_req_tag_i = 11'h000;
        mem_d_invalidate_i = 1'b0; mem_d_writeback_i = 1'b0; mem_d_flush_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        clear_req();
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [63:0] exp_inst,
                         input logic exp_err, input bit expect_resp);
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = pc;
        if (expect_resp) q_i.push_back('{inst: exp_inst, err: exp_err});
    endtask

    // ops = {invalidate, writeback, flush}
    task automatic dreq(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wr,
                        input logic rd, input logic [2:0] ops, input logic [10:0] tag,
                        input logic [31:0] exp_data, input logic exp_err, input bit expect_resp);
        mem_d_addr_i = addr; mem_d_data_wr_i = wdata; mem_d_wr_i = wr; mem_d_rd_i = rd;
        mem_d_invalidate_i = ops[2]; mem_d_writeback_i = ops[1]; mem_d_flush_i = ops[0];
        mem_d_req_tag_i = tag;
        if (expect_resp) q_d.push_back('{data: exp_data, tag: tag, err: exp_err});
    endtask

    task automatic bd_check(input logic [31:0] addr, input logic [7:0] exp_byte);
        q_bd_act.push_back(dut.read(addr));
        q_bd_exp.push_back(exp_byte);
    endtask

    // Stimulus
    initial begin
        logic [7:0] prog [0:7];
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        clear_req();
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dut.write(32'h0000_0000 + 32'(i), prog[i]);
            dut.write(32'h0000_0100 + 32'(i), 8'h00);
            dut.write(32'h0000_0200 + 32'(i), 8'(i + 1));
            dut.write(32'h0000_0300 + 32'(i), 8'h00);
            dut.write(32'h0000_1000 + 32'(i), 8'h00);
        end
        dut.write(32'h0000_1000, 8'h44); dut.write(32'h0000_1001, 8'h33);
        dut.write(32'h0000_1002, 8'h22); dut.write(32'h0000_1003, 8'h11);

        // Requests during reset must be dropped and must not store
        @(posedge clk_i); #1;
        for (int c = 0; c < 3; c++) begin
            fetch(32'h8000_0000, 64'h0, 1'b0, 1'b0);
            dreq(32'h8000_0300, 32'hDEAD_BEEF, 4'hF, 1'b1, 3'b000, 11'h055, 32'h0, 1'b0, 1'b0);
            tick();
        end
        rst_i = 1'b1;

        fetch(32'h8000_0000, 64'h00100093_00000013, 1'b0, 1'b1); tick();
        dreq(32'h8000_0300, 32'h0, 4'h0, 1'b1, 3'b000, 11'h001, 32'h0000_0000, 1'b0, 1'b1); tick();
        dreq(32'h8000_0104, 32'hAABB_CCDD, 4'b0101, 1'b0, 3'b000, 11'h005, 32'h0, 1'b0, 1'b1); tick();
        dreq(32'h8000_0104, 32'h0, 4'h0, 1'b1, 3'b000, 11'h02A, 32'h00BB_00DD, 1'b0, 1'b1); tick();

        // Store and fetch to the same word in one cycle: fetch sees the old word
        dreq(32'h8000_0200, 32'h1122_3344, 4'hF, 1'b0, 3'b000, 11'h006, 32'h0, 1'b0, 1'b1);
        fetch(32'h8000_0200, 64'h08070605_04030201, 1'b0, 1'b1);
        tick();
        fetch(32'h8000_0200, 64'h08070605_11223344, 1'b0, 1'b1); tick();
        dreq(32'h8000_0204, 32'hCAFE_F00D, 4'b0011, 1'b1, 3'b000, 11'h007, 32'h0807_0605, 1'b0, 1'b1); tick();
        dreq(32'h8000_0204, 32'h0, 4'h0, 1'b1, 3'b000, 11'h008, 32'h0807_F00D, 1'b0, 1'b1); tick();

        fetch(32'h8000_0000, 64'h00100093_00000013, 1'b0, 1'b1); tick();
        fetch(32'h8000_0204, 64'h0807F00D_11223344, 1'b0, 1'b1); tick();

        dreq(32'h8000_0104, 32'h0, 4'h0, 1'b1, 3'b000, 11'h001, 32'h00BB_00DD, 1'b0, 1'b1); tick();
        dreq(32'h8000_0200, 32'h0, 4'h0, 1'b1, 3'b000, 11'h002, 32'h1122_3344, 1'b0, 1'b1); tick();
        dreq(32'h8000_0206, 32'h0, 4'h0, 1'b1, 3'b000, 11'h003, 32'h0807_F00D, 1'b0, 1'b1); tick();

        dreq(32'h8000_0200, 32'h5555_5555, 4'h0, 1'b0, 3'b001, 11'h077, 32'h0, 1'b0, 1'b1); tick();
        dreq(32'h8000_0200, 32'h5555_5555, 4'h0, 1'b0, 3'b100, 11'h078, 32'h0, 1'b0, 1'b1); tick();
        dreq(32'h8000_0200, 32'h5555_5555, 4'h0, 1'b0, 3'b010, 11'h079, 32'h0, 1'b0, 1'b1); tick();
        dreq(32'h8000_0200, 32'h0, 4'h0, 1'b1, 3'b000, 11'h004, 32'h1122_3344, 1'b0, 1'b1); tick();
        tick(); tick();

        // Load then reset in the next cycle: its ack must never appear
        dreq(32'h8000_0104, 32'h0, 4'h0, 1'b1, 3'b000, 11'h009, 32'h0, 1'b0, 1'b0);
        fetch(32'h8000_0000, 64'h0, 1'b0, 1'b0);
        tick();
        rst_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        bd_check(32'h0000_0104, 8'hDD); bd_check(32'h0000_0105, 8'h00);
        bd_check(32'h0000_0106, 8'hBB); bd_check(32'h0000_0107, 8'h00);
        dreq(32'h8000_0104, 32'h0, 4'h0, 1'b1, 3'b000, 11'h010, 32'h00BB_00DD, 1'b0, 1'b1); tick();

        // Address outside the TCM window
        dreq(32'h0000_1000, 32'h0, 4'h0, 1'b1, 3'b000, 11'h033,
             ERR_EN ? 32'h0 : 32'h1122_3344, ERR_EN, 1'b1);
        tick();
        fetch(32'h0000_1000, ERR_EN ? 64'h0 : 64'h00000000_11223344, ERR_EN, 1'b1); tick();
        tick(); tick(); tick();
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        i_exp_t ie;
        d_exp_t de;
        while (!done) begin
            @(negedge clk_i);
            if (done) break;
            if (!rst_i) begin
                vectors++;
                if (mem_i_valid_o !== 1'b0 || mem_i_error_o !== 1'b0 || mem_i_inst_o !== 64'h0 ||
                    mem_d_ack_o !== 1'b0 || mem_d_error_o !== 1'b0 || mem_d_data_rd_o !== 32'h0 ||
                    mem_d_resp_tag_o !== 11'h000 || mem_i_accept_o !== 1'b1 || mem_d_accept_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reset_outputs: got valid=%b ierr=%b inst=%h ack=%b derr=%b data=%h tag=%h, want all 0",
                             mem_i_valid_o, mem_i_error_o, mem_i_inst_o, mem_d_ack_o,
                             mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o);
                end
            end else begin
                if (mem_i_valid_o === 1'b1) begin
                    vectors++;
                    if (q_i.size() == 0) begin
                        miscompares++;
                        $display("FAIL fetch_unexpected: got valid=1 inst=%h, want no response", mem_i_inst_o);
                    end else begin
                        ie = q_i.pop_front();
                        if (mem_i_inst_o !== ie.inst || mem_i_error_o !== ie.err) begin
                            miscompares++;
                            $display("FAIL fetch: got inst=%h err=%b, want inst=%h err=%b",
                                     mem_i_inst_o, mem_i_error_o, ie.inst, ie.err);
                        end
                    end
                end
                if (mem_d_ack_o === 1'b1) begin
                    vectors++;
                    if (q_d.size() == 0) begin
                        miscompares++;
                        $display("FAIL data_unexpected: got ack=1 tag=%h, want no response", mem_d_resp_tag_o);
                    end else begin
                        de = q_d.pop_front();
                        if (mem_d_data_rd_o !== de.data || mem_d_resp_tag_o !== de.tag ||
                            mem_d_error_o !== de.err) begin
                            miscompares++;
                            $display("FAIL data: got data=%h tag=%h err=%b, want data=%h tag=%h err=%b",
                                     mem_d_data_rd_o, mem_d_resp_tag_o, mem_d_error_o,
                                     de.data, de.tag, de.err);
                        end
                    end
                end
            end
        end
        vectors++;
        if (q_i.size() != 0) begin
            miscompares++;
            $display("FAIL fetch_missing: got %0d responses outstanding, want 0", q_i.size());
        end
        vectors++;
        if (q_d.size() != 0) begin
            miscompares++;
            $display("FAIL data_missing: got %0d responses outstanding, want 0", q_d.size());
        end
        while (q_bd_act.size() != 0 && q_bd_exp.size() != 0) begin
            logic [7:0] a, e;
            a = q_bd_act.pop_front();
            e = q_bd_exp.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL backdoor_byte: got %h, want %h", a, e);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
